// File: rtl/moore5_pkg.sv
// Shared types and the golden transition table for the 5-state Moore stepper.
package moore5_pkg;

    localparam int STATE_W  = 3;
    localparam int N_STATES = 5;
    localparam int SW_W     = 2;

    // Expected stepper response to one step: next state and Moore output.
    typedef struct packed {
        logic [STATE_W-1:0] nxt;
        logic               out;
    } exp_t;

    // Checker control FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fsm_t;

    // Golden table G[state][sw] = {next, out}, encoded as next*2 + out.
    localparam logic [STATE_W:0] G [0:N_STATES-1][0:3] = '{
        '{4'h2, 4'h1, 4'h6, 4'h9},   // s0: {1,0} {0,1} {3,0} {4,1}
        '{4'h6, 4'h1, 4'h1, 4'h9},   // s1: {3,0} {0,1} {0,1} {4,1}
        '{4'h5, 4'h5, 4'h6, 4'h2},   // s2: {2,1} {2,1} {3,0} {1,0}
        '{4'h9, 4'h5, 4'h2, 4'h9},   // s3: {4,1} {2,1} {1,0} {4,1}
        '{4'h5, 4'h6, 4'h1, 4'h1}    // s4: {2,1} {3,0} {0,1} {0,1}
    };

endpackage

// File: rtl/moore5_golden.sv
// Combinational golden lookup: (current state, input symbol) -> expected {next, out}.
// An out-of-range current state yields {cur, ~dut_out} and raises o_invalid so
// the comparison downstream is guaranteed to fail.
module moore5_golden
    import moore5_pkg::*;
(
    input  logic [STATE_W-1:0] i_cur,
    input  logic [SW_W-1:0]    i_sw,
    input  logic               i_dut_out,
    output exp_t               o_exp,
    output logic               o_invalid
);

    // Table lookup with invalid-state fallback.
    always_comb begin
        o_exp     = '0;
        o_invalid = 1'b0;
        if (i_cur < STATE_W'(N_STATES)) begin
            o_exp = G[i_cur][i_sw];
        end else begin
            o_exp.nxt = i_cur;
            o_exp.out = ~i_dut_out;
            o_invalid = 1'b1;
        end
    end

endmodule

// File: rtl/moore_trace_checker.sv
// Mirrors each step of the 5-state Moore stepper, compares its registered
// state/out one cycle after the step against the golden table and keeps
// pass/fail statistics plus a first-failure snapshot for debug.
module moore_trace_checker
    import moore5_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int RESYNC      = 1,
    parameter int STOP_ON_ERR = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state_init,
    input  logic [SW_W-1:0]    sw_in,
    input  logic               step,
    input  logic [STATE_W-1:0] dut_state,
    input  logic               dut_out,
    output logic               chk_valid,
    output logic               chk_match,
    output logic               err_flag,
    output logic               halted,
    output logic [CNT_W-1:0]   step_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   first_err_step,
    output logic [3:0]         first_err_exp,
    output logic [3:0]         first_err_got
);

    fsm_t               r_fsm;
    logic               r_halted;
    logic [STATE_W-1:0] r_shadow;
    exp_t               r_exp;
    logic               r_exp_bad;
    logic [CNT_W-1:0]   r_exp_step;
    logic               r_pending;
    logic [CNT_W-1:0]   r_step_cnt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_chk_valid;
    logic               r_chk_match;
    logic               r_err_flag;
    logic [CNT_W-1:0]   r_first_step;
    logic [3:0]         r_first_exp;
    logic [3:0]         r_first_got;

    logic [STATE_W-1:0] w_cur;
    exp_t               w_gold;
    logic               w_gold_bad;
    logic               w_accept;
    logic               w_equal;
    logic               w_mis;
    logic [CNT_W-1:0]   w_step_next;
    logic [CNT_W-1:0]   w_err_next;

    // Per-transition check follows the stepper; trace check follows our own shadow.
    assign w_cur = (RESYNC != 0) ? dut_state : r_shadow;

    moore5_golden u_golden (
        .i_cur     (w_cur),
        .i_sw      (sw_in),
        .i_dut_out (dut_out),
        .o_exp     (w_gold),
        .o_invalid (w_gold_bad)
    );

    assign w_accept    = step && (r_fsm != ST_HALT);
    assign w_equal     = !r_exp_bad && (dut_state == r_exp.nxt) && (dut_out == r_exp.out);
    assign w_mis       = r_pending && !w_equal;
    assign w_step_next = (&r_step_cnt) ? r_step_cnt : (r_step_cnt + CNT_W'(1));
    assign w_err_next  = (&r_err_cnt)  ? r_err_cnt  : (r_err_cnt  + CNT_W'(1));

    // Step acceptance: load expectation, advance shadow, count the step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow   <= state_init;
            r_exp      <= '0;
            r_exp_bad  <= 1'b0;
            r_exp_step <= '0;
            r_pending  <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            r_pending <= w_accept;
            if (w_accept) begin
                r_exp      <= w_gold;
                r_exp_bad  <= w_gold_bad;
                r_exp_step <= w_step_next;
                r_shadow   <= w_gold.nxt;
                r_step_cnt <= w_step_next;
            end
        end
    end

    // Compare stage: one registered result per pending expectation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chk_valid <= 1'b0;
            r_chk_match <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_chk_valid <= r_pending;
            r_chk_match <= r_pending && w_equal;
            if (w_mis) begin
                r_err_flag <= 1'b1;
                r_err_cnt  <= w_err_next;
            end
        end
    end

    // Snapshot of the first mismatch since reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first_step <= '0;
            r_first_exp  <= 4'h0;
            r_first_got  <= 4'h0;
        end else begin
            if (w_mis && !r_err_flag) begin
                r_first_step <= r_exp_step;
                r_first_exp  <= r_exp;
                r_first_got  <= {dut_state, dut_out};
            end
        end
    end

    // Control FSM: IDLE until first step, optional HALT on first mismatch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm    <= ST_IDLE;
            r_halted <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_fsm <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_mis && (STOP_ON_ERR != 0)) begin
                        r_fsm    <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_fsm    <= ST_HALT;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_fsm    <= ST_IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign chk_valid      = r_chk_valid;
    assign chk_match      = r_chk_match;
    assign err_flag       = r_err_flag;
    assign halted         = r_halted;
    assign step_count     = r_step_cnt;
    assign err_count      = r_err_cnt;
    assign first_err_step = r_first_step;
    assign first_err_exp  = r_first_exp;
    assign first_err_got  = r_first_got;

endmodule

// File: tb/tb_moore_trace_checker.sv
// Directed bench for moore_trace_checker. Four instances share one stimulus:
// A default, B trace mode (RESYNC=0), C STOP_ON_ERR=1, D CNT_W=2.
module tb_moore_trace_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] state_init = 3'd0;
    logic [1:0] sw_in = 2'd0;
    logic       step = 1'b0;
    logic [2:0] dut_state = 3'd0;
    logic       dut_out = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic        v_a, m_a, e_a, h_a;
    logic [15:0] sc_a, ec_a, fs_a;
    logic [3:0]  fe_a, fg_a;
    logic        v_b, m_b, e_b, h_b;
    logic [15:0] sc_b, ec_b, fs_b;
    logic [3:0]  fe_b, fg_b;
    logic        v_c, m_c, e_c, h_c;
    logic [15:0] sc_c, ec_c, fs_c;
    logic [3:0]  fe_c, fg_c;
    logic        v_d, m_d, e_d, h_d;
    logic [1:0]  sc_d, ec_d, fs_d;
    logic [3:0]  fe_d, fg_d;

    always #5 clk = ~clk;

    moore_trace_checker #(.CNT_W(16), .RESYNC(1), .STOP_ON_ERR(0)) dut_a (
        .clk(clk), .reset(reset), .state_init(state_init), .sw_in(sw_in), .step(step),
        .dut_state(dut_state), .dut_out(dut_out), .chk_valid(v_a), .chk_match(m_a),
        .err_flag(e_a), .halted(h_a), .step_count(sc_a), .err_count(ec_a),
        .first_err_step(fs_a), .first_err_exp(fe_a), .first_err_got(fg_a));

    moore_trace_checker #(.CNT_W(16), .RESYNC(0), .STOP_ON_ERR(0)) dut_b (
        .clk(clk), .reset(reset), .state_init(state_init), .sw_in(sw_in), .step(step),
        .dut_state(dut_state), .dut_out(dut_out), .chk_valid(v_b), .chk_match(m_b),
        .err_flag(e_b), .halted(h_b), .step_count(sc_b), .err_count(ec_b),
        .first_err_step(fs_b), .first_err_exp(fe_b), .first_err_got(fg_b));

    moore_trace_checker #(.CNT_W(16), .RESYNC(1), .STOP_ON_ERR(1)) dut_c (
        .clk(clk), .reset(reset), .state_init(state_init), .sw_in(sw_in), .step(step),
        .dut_state(dut_state), .dut_out(dut_out), .chk_valid(v_c), .chk_match(m_c),
        .err_flag(e_c), .halted(h_c), .step_count(sc_c), .err_count(ec_c),
        .first_err_step(fs_c), .first_err_exp(fe_c), .first_err_got(fg_c));

    moore_trace_checker #(.CNT_W(2), .RESYNC(1), .STOP_ON_ERR(0)) dut_d (
        .clk(clk), .reset(reset), .state_init(state_init), .sw_in(sw_in), .step(step),
        .dut_state(dut_state), .dut_out(dut_out), .chk_valid(v_d), .chk_match(m_d),
        .err_flag(e_d), .halted(h_d), .step_count(sc_d), .err_count(ec_d),
        .first_err_step(fs_d), .first_err_exp(fe_d), .first_err_got(fg_d));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] init);
        reset      = 1'b1;
        state_init = init;
        dut_state  = init;
        dut_out    = 1'b0;
        step       = 1'b0;
        sw_in      = 2'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One step; stepper registers (ns, no) on the accepting edge.
    // Returns in the cycle where the result is visible (step + 2).
    task automatic step_once(input logic [1:0] sw, input logic [2:0] ns, input logic no);
        step  = 1'b1;
        sw_in = sw;
        tick();
        step      = 1'b0;
        dut_state = ns;
        dut_out   = no;
        tick();
    endtask

    // Correct trace from s0 with sw 0,2,1,3,0,1,2,3.
    logic [1:0] bb_sw [0:7] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [2:0] bb_ns [0:7] = '{3'd1, 3'd0, 3'd0, 3'd4, 3'd2, 3'd2, 3'd3, 3'd4};
    logic       bb_no [0:7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int pulses;

        // ---- 1: reset state and three correct steps from s0
        do_reset(3'd0);
        chk("rst_valid", {31'd0, v_a}, 32'd0);
        chk("rst_match", {31'd0, m_a}, 32'd0);
        chk("rst_err_flag", {31'd0, e_a}, 32'd0);
        chk("rst_halted", {31'd0, h_a}, 32'd0);
        chk("rst_step_count", {16'd0, sc_a}, 32'd0);
        chk("rst_err_count", {16'd0, ec_a}, 32'd0);
        chk("rst_first", {16'd0, fs_a, fe_a, fg_a}, 32'd0);
        step_once(2'd0, 3'd1, 1'b0);
        chk("t1_s1_valid", {31'd0, v_a}, 32'd1);
        chk("t1_s1_match", {31'd0, m_a}, 32'd1);
        step_once(2'd2, 3'd0, 1'b1);
        chk("t1_s2_valid", {31'd0, v_a}, 32'd1);
        chk("t1_s2_match", {31'd0, m_a}, 32'd1);
        step_once(2'd1, 3'd0, 1'b1);
        chk("t1_s3_valid", {31'd0, v_a}, 32'd1);
        chk("t1_s3_match", {31'd0, m_a}, 32'd1);
        tick();
        chk("t1_valid_drop", {31'd0, v_a}, 32'd0);
        chk("t1_step_count", {16'd0, sc_a}, 32'd3);
        chk("t1_err_count", {16'd0, ec_a}, 32'd0);
        chk("t1_err_flag", {31'd0, e_a}, 32'd0);

        // ---- 2: s1 sw=1 expects {0,1}; stepper goes to {4,0}
        do_reset(3'd1);
        step_once(2'd1, 3'd4, 1'b0);
        chk("t2_valid", {31'd0, v_a}, 32'd1);
        chk("t2_match", {31'd0, m_a}, 32'd0);
        chk("t2_err_flag", {31'd0, e_a}, 32'd1);
        chk("t2_err_count", {16'd0, ec_a}, 32'd1);
        chk("t2_first_exp", {28'd0, fe_a}, 32'h1);
        chk("t2_first_got", {28'd0, fg_a}, 32'h8);
        chk("t2_first_step", {16'd0, fs_a}, 32'd1);
        chk("t2_halted_a", {31'd0, h_a}, 32'd0);

        // ---- 3: s2 sw=2 expects {3,0}; stepper goes to {0,0}; then sw=0
        do_reset(3'd2);
        step_once(2'd2, 3'd0, 1'b0);
        chk("t3_a_match1", {31'd0, m_a}, 32'd0);
        chk("t3_b_match1", {31'd0, m_b}, 32'd0);
        chk("t3_b_first_exp", {28'd0, fe_b}, 32'h6);
        step_once(2'd0, 3'd1, 1'b0);
        chk("t3_a_match2", {31'd0, m_a}, 32'd1);
        chk("t3_b_valid2", {31'd0, v_b}, 32'd1);
        chk("t3_b_match2", {31'd0, m_b}, 32'd0);
        chk("t3_a_err_count", {16'd0, ec_a}, 32'd1);
        chk("t3_b_err_count", {16'd0, ec_b}, 32'd2);
        chk("t3_b_first_step", {16'd0, fs_b}, 32'd1);

        // ---- 4: STOP_ON_ERR, s4 sw=0 expects {2,1}; stepper gives out=0
        do_reset(3'd4);
        step_once(2'd0, 3'd2, 1'b0);
        chk("t4_c_valid", {31'd0, v_c}, 32'd1);
        chk("t4_c_match", {31'd0, m_c}, 32'd0);
        chk("t4_c_halted", {31'd0, h_c}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step_once(2'd1, 3'd2, 1'b1);
            chk("t4_c_no_valid", {31'd0, v_c}, 32'd0);
        end
        chk("t4_c_step_count", {16'd0, sc_c}, 32'd1);
        chk("t4_c_err_count", {16'd0, ec_c}, 32'd1);
        chk("t4_c_still_halted", {31'd0, h_c}, 32'd1);
        chk("t4_a_step_count", {16'd0, sc_a}, 32'd6);
        chk("t4_a_halted", {31'd0, h_a}, 32'd0);

        // ---- 5: eight back-to-back correct steps, 2-cycle latency
        do_reset(3'd0);
        pulses = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c >= 1 && c <= 8) begin
                dut_state = bb_ns[c-1];
                dut_out   = bb_no[c-1];
            end
            if (c < 8) begin
                step  = 1'b1;
                sw_in = bb_sw[c];
            end else begin
                step = 1'b0;
            end
            chk("t5_valid_timing", {31'd0, v_a}, (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
            if (v_a === 1'b1) begin
                pulses++;
                chk("t5_match", {31'd0, m_a}, 32'd1);
            end
            tick();
        end
        chk("t5_pulses", pulses, 32'd8);
        chk("t5_step_count", {16'd0, sc_a}, 32'd8);
        chk("t5_err_count", {16'd0, ec_a}, 32'd0);
        chk("t5_b_err_count", {16'd0, ec_b}, 32'd0);

        // ---- 6: reset while a compare is pending
        do_reset(3'd0);
        step  = 1'b1;
        sw_in = 2'd0;
        tick();
        step      = 1'b0;
        dut_state = 3'd1;
        reset     = 1'b1;
        #1;
        chk("t6_rst_step_count", {16'd0, sc_a}, 32'd0);
        chk("t6_rst_valid", {31'd0, v_a}, 32'd0);
        tick();
        dut_state = 3'd0;
        reset     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_valid_after", {31'd0, v_a}, 32'd0);
        end
        chk("t6_err_flag", {31'd0, e_a}, 32'd0);

        // ---- 6b: CNT_W=2 saturation over five correct steps
        for (int i = 0; i < 5; i++) begin
            step_once(bb_sw[i], bb_ns[i], bb_no[i]);
        end
        chk("t6_d_step_sat", {30'd0, sc_d}, 32'd3);
        chk("t6_d_err_count", {30'd0, ec_d}, 32'd0);
        chk("t6_a_step_count", {16'd0, sc_a}, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
